// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared state encoding and default watchdog limit for the
// MAC burst sequencer.
package mac_seq_pkg;

  // Default number of MUL_WAIT cycles before the watchdog gives up.
  localparam int unsigned TMO_CYC_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_OP,
    LOAD,
    MUL_START,
    MUL_WAIT,
    ACC,
    DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_watchdog.sv
// mac_seq_watchdog: end_mul rising-edge detector plus the multiply-phase
// timeout counter. 'clear' zeroes the counter at the start of a multiply,
// 'arm' qualifies edge detection and counting while the multiply is pending.
module mac_seq_watchdog
  import mac_seq_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic clear,
  input  logic end_mul,
  output logic rise,
  output logic expired
);

  localparam int unsigned CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC - 1);

  logic             end_mul_q;
  logic [CNT_W-1:0] cnt;

  // Track end_mul every cycle so a level already high when the multiply
  // begins looks stale; count armed cycles up to the limit.
  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously on the falling edge of the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      end_mul_q <= 1'b0;
      cnt       <= '0;
    end else begin
      end_mul_q <= end_mul;
      if (clear) begin
        cnt <= '0;
      end else if (arm && (cnt != LIMIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise    = arm & end_mul & ~end_mul_q;
  assign expired = arm & (cnt == LIMIT);

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: runs a burst of multiply-accumulate operations, pulling one
// operand pair per operation over valid/ready and issuing the datapath
// commands. Command outputs are decoded from the state register.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear_acc,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             load_op,
  output logic             begin_mul,
  input  logic             end_mul,
  output logic             add,
  output logic             acc_clear,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] op_count
);

  mac_seq_state_t   state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_inc;
  logic             mul_rise;
  logic             mul_expired;

  assign count_inc = op_count + LEN_W'(1);

  mac_seq_watchdog #(
    .TMO_CYC (TMO_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .arm     (state == MUL_WAIT),
    .clear   (state == MUL_START),
    .end_mul (end_mul),
    .rise    (mul_rise),
    .expired (mul_expired)
  );

  // Sequencer FSM with the latched length, op counter and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len_q    <= '0;
      op_count <= '0;
      error    <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Abort beats every other event; op_count keeps its value.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= burst_len;
            op_count <= '0;
            error    <= 1'b0;
            if (burst_len == '0) begin
              state <= DONE;
            end else if (clear_acc) begin
              state <= CLEAR;
            end else begin
              state <= WAIT_OP;
            end
          end
        end
        CLEAR:     state <= WAIT_OP;
        WAIT_OP: begin
          if (op_valid) begin
            state <= LOAD;
          end
        end
        LOAD:      state <= MUL_START;
        MUL_START: state <= MUL_WAIT;
        MUL_WAIT: begin
          // A real completion edge wins over a same-cycle timeout.
          if (mul_rise) begin
            state <= ACC;
          end else if (mul_expired) begin
            error <= 1'b1;
            state <= DONE;
          end
        end
        ACC: begin
          if (op_count != len_q) begin
            op_count <= count_inc;
          end
          if (count_inc == len_q) begin
            state <= DONE;
          end else begin
            state <= WAIT_OP;
          end
        end
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Moore decode of the command pulses; one state per pulse keeps them disjoint.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op_ready  = 1'b0;
    load_op   = 1'b0;
    begin_mul = 1'b0;
    add       = 1'b0;
    acc_clear = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      CLEAR:     acc_clear = 1'b1;
      WAIT_OP:   op_ready  = 1'b1;
      LOAD:      load_op   = 1'b1;
      MUL_START: begin_mul = 1'b1;
      ACC:       add       = 1'b1;
      DONE:      done      = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed bench for mac_sequencer. Each burst is run for a
// fixed window; cycle 0 is the cycle in which start is presented, and the
// first cycle each output pulses is recorded and compared with hand-derived
// values. A small multiplier model raises end_mul mul_lat cycles after
// begin_mul, or holds it stuck high.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear_acc;
  logic [3:0] burst_len;
  logic       abort;
  logic       op_valid;
  logic       op_ready;
  logic       load_op;
  logic       begin_mul;
  logic       end_mul = 1'b0;
  logic       add;
  logic       acc_clear;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] op_count;

  mac_sequencer #(
    .LEN_W   (4),
    .TMO_CYC (24)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear_acc (clear_acc),
    .burst_len (burst_len),
    .abort     (abort),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .load_op   (load_op),
    .begin_mul (begin_mul),
    .end_mul   (end_mul),
    .add       (add),
    .acc_clear (acc_clear),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Multiplier model: end_mul drops with begin_mul and rises mul_lat cycles later.
  int mul_lat   = 9;
  bit mul_stuck = 1'b0;
  int mul_rem   = 0;
  always @(negedge clk) begin
    if (mul_stuck) begin
      end_mul = 1'b1;
    end else if (begin_mul === 1'b1) begin
      end_mul = 1'b0;
      mul_rem = mul_lat;
    end else if (mul_rem > 0) begin
      mul_rem = mul_rem - 1;
      if (mul_rem == 0) end_mul = 1'b1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Per-window observations.
  int n_load, n_begin, n_add, n_clear, n_done, n_ready, n_ready_gap, n_busy;
  int f_load, f_begin, f_add, f_clear, f_done, f_ready, f_error;
  logic err_at0, err_at1;
  int gap_lo     = -1;
  int gap_hi     = -1;
  int abort_at   = -1;
  int restart_at = -1;

  task automatic run_burst(input logic [3:0] len, input logic clr, input int ncyc);
    n_load = 0; n_begin = 0; n_add = 0; n_clear = 0; n_done = 0;
    n_ready = 0; n_ready_gap = 0; n_busy = 0;
    f_load = -1; f_begin = -1; f_add = -1; f_clear = -1; f_done = -1;
    f_ready = -1; f_error = -1;
    for (int i = 0; i < ncyc; i++) begin
      if (load_op)   begin if (f_load  < 0) f_load  = i; n_load++;  end
      if (begin_mul) begin if (f_begin < 0) f_begin = i; n_begin++; end
      if (add)       begin if (f_add   < 0) f_add   = i; n_add++;   end
      if (acc_clear) begin if (f_clear < 0) f_clear = i; n_clear++; end
      if (done)      begin if (f_done  < 0) f_done  = i; n_done++;  end
      if (op_ready)  begin
        if (f_ready < 0) f_ready = i;
        n_ready++;
        if (i >= gap_lo && i < gap_hi) n_ready_gap++;
      end
      if (busy) n_busy++;
      if (error && f_error < 0) f_error = i;
      if (i == 0) err_at0 = error;
      if (i == 1) err_at1 = error;
      start     = (i == 0) || (i == restart_at);
      burst_len = len;
      clear_acc = clr;
      abort     = (i == abort_at);
      op_valid  = !(i >= gap_lo && i < gap_hi);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    clear_acc = 1'b0;
    burst_len = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_op_ready",  op_ready,  0);
    check("rst_load_op",   load_op,   0);
    check("rst_begin_mul", begin_mul, 0);
    check("rst_add",       add,       0);
    check("rst_acc_clear", acc_clear, 0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_error",     error,     0);
    check("rst_op_count",  op_count,  0);
    reset = 1'b1;
    @(negedge clk);

    // Single op with clear, end_mul 9 cycles after begin_mul.
    mul_lat = 9;
    run_burst(4'd1, 1'b1, 20);
    check("t1_acc_clear_cyc", f_clear, 1);
    check("t1_op_ready_cyc",  f_ready, 2);
    check("t1_load_op_cyc",   f_load,  3);
    check("t1_begin_mul_cyc", f_begin, 4);
    check("t1_add_cyc",       f_add,   14);
    check("t1_done_cyc",      f_done,  15);
    check("t1_add_count",     n_add,   1);
    check("t1_done_count",    n_done,  1);
    check("t1_op_count",      op_count, 1);
    check("t1_error",         error,   0);

    // Three ops, upstream idle for cycles 8..12 before the second op.
    mul_lat = 3;
    gap_lo  = 8;
    gap_hi  = 13;
    run_burst(4'd3, 1'b0, 32);
    gap_lo  = -1;
    gap_hi  = -1;
    check("t2_op_ready_cyc",   f_ready,     1);
    check("t2_ready_in_gap",   n_ready_gap, 5);
    check("t2_ready_count",    n_ready,     8);
    check("t2_add_count",      n_add,       3);
    check("t2_done_count",     n_done,      1);
    check("t2_done_cyc",       f_done,      27);
    check("t2_op_count",       op_count,    3);

    // end_mul stuck high: 24 MUL_WAIT cycles (4..27), then error and done.
    mul_stuck = 1'b1;
    @(negedge clk);
    run_burst(4'd1, 1'b0, 32);
    check("t3_begin_mul_cyc", f_begin, 3);
    check("t3_add_count",     n_add,   0);
    check("t3_done_cyc",      f_done,  28);
    check("t3_done_count",    n_done,  1);
    check("t3_error_cyc",     f_error, 28);
    check("t3_error_sticky",  error,   1);
    mul_stuck = 1'b0;

    // Zero-length burst straight to DONE; the accepted start clears error.
    run_burst(4'd0, 1'b0, 6);
    check("t4_error_before",  err_at0, 1);
    check("t4_error_cleared", err_at1, 0);
    check("t4_done_cyc",      f_done,  1);
    check("t4_done_count",    n_done,  1);
    check("t4_load_count",    n_load,  0);
    check("t4_begin_count",   n_begin, 0);
    check("t4_add_count",     n_add,   0);
    check("t4_ready_count",   n_ready, 0);
    check("t4_op_count",      op_count, 0);

    // Abort on the end_mul edge of op 2 of 4 (cycle 13); start at 5 ignored.
    mul_lat    = 3;
    abort_at   = 13;
    restart_at = 5;
    run_burst(4'd4, 1'b0, 20);
    abort_at   = -1;
    restart_at = -1;
    check("t5_add_count",  n_add,   1);
    check("t5_done_count", n_done,  0);
    check("t5_load_count", n_load,  2);
    check("t5_busy_count", n_busy,  13);
    check("t5_op_count",   op_count, 1);
    check("t5_busy_after", busy,    0);

    // Reset pulsed during MUL_WAIT of op 2, then a normal burst.
    run_burst(4'd2, 1'b0, 11);
    check("t6_busy_pre",     busy,     1);
    check("t6_op_count_pre", op_count, 1);
    reset = 1'b0;
    #1;
    check("t6_busy_rst",     busy,      0);
    check("t6_op_count_rst", op_count,  0);
    check("t6_op_ready_rst", op_ready,  0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mul_lat = 9;
    run_burst(4'd1, 1'b1, 20);
    check("t6_add_cyc",   f_add,    14);
    check("t6_done_cyc",  f_done,   15);
    check("t6_op_count",  op_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
